// File: rtl/reg_dump_tx.sv
// reg_dump_tx: debug register-bank dumper.
// On a start pulse, walks bank addresses 0..REG_SIZE-1 through the bank's
// debug read port, snapshots each value and streams it LSB-byte first to a
// UART transmitter over a valid/ready byte handshake.
//
// Ports:
//   i_clk       clock, rising edge
//   i_reset     asynchronous reset, active low
//   i_start     one-cycle dump request, honoured only when idle
//   o_addr_reg  address to the bank debug read port
//   i_data_reg  combinational read data from the bank debug port
//   o_tx_byte   byte offered to the UART TX
//   o_tx_valid  o_tx_byte valid, held stable until accepted
//   i_tx_ready  TX accepts when o_tx_valid and i_tx_ready are both high
//   o_busy      dump in progress
//   o_done      one-cycle pulse after the last byte has been accepted
//
// Optional feature (macro REG_DUMP_CHECKSUM_EN): a running XOR of all data
// bytes is appended as one extra byte after the last register.
module reg_dump_tx #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int REG_SIZE  = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [BITS_REGS-1:0] o_addr_reg,
  input  logic [BITS_SIZE-1:0] i_data_reg,
  output logic [BYTE_SIZE-1:0] o_tx_byte,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NBYTES = BITS_SIZE / BYTE_SIZE;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_SEND, S_NEXT, S_CHK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_SEND, S_NEXT, S_DONE
  } state_t;
`endif

  state_t               state;
  logic [BITS_REGS-1:0] counter;
  logic [IDXW-1:0]      byte_idx;
  logic [BITS_SIZE-1:0] snapshot;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [BYTE_SIZE-1:0] chk;
`endif

  logic                 xfer;
  logic                 last_byte;
  logic                 last_reg;
  logic [IDXW-1:0]      next_idx;
  logic [BYTE_SIZE-1:0] next_byte;

  always_comb begin
    xfer      = o_tx_valid & i_tx_ready;
    last_byte = (byte_idx == IDXW'(NBYTES - 1));
    last_reg  = (counter == BITS_REGS'(REG_SIZE - 1));
    next_idx  = byte_idx + 1'b1;
    // Only consumed when byte_idx is not the last one, so wrap is harmless.
    next_byte = snapshot[int'(next_idx) * BYTE_SIZE +: BYTE_SIZE];
  end

  // Outputs are registered: each is loaded on the transition into the state
  // that owns it, so the value is present for the whole state cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      counter    <= '0;
      byte_idx   <= '0;
      snapshot   <= '0;
      o_addr_reg <= '0;
      o_tx_byte  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_ADDR;
            counter    <= '0;
            o_addr_reg <= '0;
            o_busy     <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            chk        <= '0;
`endif
          end
        end

        S_ADDR: state <= S_LATCH;

        S_LATCH: begin
          snapshot   <= i_data_reg;
          byte_idx   <= '0;
          o_tx_byte  <= i_data_reg[BYTE_SIZE-1:0];
          o_tx_valid <= 1'b1;
          state      <= S_SEND;
        end

        S_SEND: begin
          if (xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
            chk <= chk ^ o_tx_byte;
`endif
            if (last_byte) begin
              o_tx_valid <= 1'b0;
              state      <= S_NEXT;
            end else begin
              byte_idx  <= next_idx;
              o_tx_byte <= next_byte;
            end
          end
        end

        S_NEXT: begin
          if (last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // chk already includes the final data byte accepted in SEND.
            o_tx_byte  <= chk;
            o_tx_valid <= 1'b1;
            state      <= S_CHK;
`else
            o_done <= 1'b1;
            state  <= S_DONE;
`endif
          end else begin
            counter    <= counter + 1'b1;
            o_addr_reg <= counter + 1'b1;
            state      <= S_ADDR;
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            o_tx_valid <= 1'b0;
            o_done     <= 1'b1;
            state      <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          o_busy  <= 1'b0;
          counter <= '0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
module tb_reg_dump_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [4:0] addr;
  logic [31:0] data;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       busy;
  logic       done;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  always #5 clk = ~clk;

  logic [31:0] bank [32];
  logic [31:0] img  [32];
  assign data = bank[addr];

  reg_dump_tx #(.BITS_SIZE(32), .BITS_REGS(5), .REG_SIZE(32), .BYTE_SIZE(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start),
    .o_addr_reg(addr), .i_data_reg(data),
    .o_tx_byte(tx_byte), .o_tx_valid(tx_valid), .i_tx_ready(ready),
    .o_busy(busy), .o_done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0;
  logic busy_q = 1'b0;

  // Monitor: handshake signals are stable around the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_valid && ready) rx.push_back(tx_byte);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy && !busy_q) busy_cyc = cyc;
    busy_q = busy;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic build_expected();
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    exp_q.delete();
    for (int n = 0; n < 32; n++) begin
      w = img[n];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[b*8 +: 8]);
        x = x ^ w[b*8 +: 8];
      end
    end
    if (EXTRA != 0) exp_q.push_back(x);
  endtask

  function automatic int first_diff();
    if (rx.size() != exp_q.size()) return -2;
    foreach (rx[i]) if (rx[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    int d;
    checks++;
    if ({addr, tx_byte, tx_valid, busy, done} !== '0) begin
      errors++; $display("FAIL reset_idle: got %h required 0", {addr, tx_byte, tx_valid, busy, done});
    end
    rst_n = 1'b1; ready = 1'b1;
    for (int n = 0; n < 32; n++) bank[n] = 32'h0F0F0000 + n;
    tick();
    pulse_start();
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b required 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", addr); end
    checks++;
    if (tx_byte !== 8'd0) begin errors++; $display("FAIL reset_byte: got %h required 0", tx_byte); end
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", tx_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    tick(); tick();
    rst_n = 1'b1;
    rx.delete();
    d = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (tx_valid || busy) d++; end
    checks++;
    if (d !== 0) begin errors++; $display("FAIL reset_release_active: got %0d cycles required 0", d); end
    checks++;
    if (rx.size() !== 0) begin errors++; $display("FAIL reset_release_bytes: got %0d required 0", rx.size()); end
  endtask

  task automatic test_full_dump();
    int base, d;
    bit ok;
    for (int n = 0; n < 32; n++) begin bank[n] = 32'hA5000000 + n; img[n] = bank[n]; end
    build_expected();
    rx.delete(); ready = 1'b1; base = done_cnt; ok = 0;
    pulse_start();
    for (int i = 0; i < 400; i++) begin tick(); if (done_cnt > base) begin ok = 1; break; end end
    tick(); tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: got no done required done within 400 cycles"); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL full_stream: got size %0d diff at %0d required size %0d", rx.size(), d, exp_q.size());
    end
    checks++;
    if (done_cnt - base !== 1) begin errors++; $display("FAIL full_done_count: got %0d required 1", done_cnt - base); end
    checks++;
    if (done_cyc - busy_cyc !== 224 + EXTRA) begin
      errors++; $display("FAIL full_latency: got %0d required %0d", done_cyc - busy_cyc, 224 + EXTRA);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_backpressure();
    int base, d, held;
    for (int n = 0; n < 32; n++) bank[n] = 32'h0;
    bank[3] = 32'h11223344;
    for (int n = 0; n < 32; n++) img[n] = bank[n];
    build_expected();
    rx.delete(); ready = 1'b1; base = done_cnt; held = 0;
    pulse_start();
    for (int i = 0; i < 400 && done_cnt == base; i++) begin
      tick();
      if (held == 0 && tx_valid && tx_byte == 8'h22 && addr == 5'd3) begin
        held = 1;
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (tx_byte !== 8'h22 || tx_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold%0d: got byte %h valid %b required 22 1", k, tx_byte, tx_valid);
          end
          tick();
        end
        ready = 1'b1;
      end
    end
    tick(); tick();
    checks++;
    if (held !== 1) begin errors++; $display("FAIL bp_reached: got %0d required 1", held); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL bp_stream: got size %0d diff at %0d required size %0d", rx.size(), d, exp_q.size());
    end
  endtask

  task automatic test_snapshot();
    int base, d;
    bit wrote;
    for (int n = 0; n < 32; n++) begin bank[n] = 32'hC0DE0000 | n; img[n] = bank[n]; end
    build_expected();
    rx.delete(); ready = 1'b1; base = done_cnt; wrote = 0;
    pulse_start();
    for (int i = 0; i < 400 && done_cnt == base; i++) begin
      tick();
      if (!wrote && tx_valid && addr == 5'd4) begin bank[4] = 32'hDEADBEEF; wrote = 1; end
    end
    tick(); tick();
    checks++;
    if (!wrote) begin errors++; $display("FAIL snap_write: got no write required write during reg 4"); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL snap_stream: got size %0d diff at %0d required size %0d", rx.size(), d, exp_q.size());
    end
  endtask

  task automatic test_start_busy();
    int base, d;
    for (int n = 0; n < 32; n++) begin bank[n] = 32'hA5000000 + n; img[n] = bank[n]; end
    build_expected();
    rx.delete(); ready = 1'b1; base = done_cnt;
    pulse_start();
    for (int i = 0; i < 400 && done_cnt == base; i++) begin
      start = (i == 50);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL busy_stream: got size %0d diff at %0d required size %0d", rx.size(), d, exp_q.size());
    end
    checks++;
    if (done_cnt - base !== 1) begin errors++; $display("FAIL busy_done_count: got %0d required 1", done_cnt - base); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b required 0", busy); end
  endtask

`ifdef REG_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    int base;
    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < 32; n++) bank[n] = (p == 0) ? 32'h01020304 : 32'h0;
      if (p == 1) bank[0] = 32'h000000FF;
      rx.delete(); ready = 1'b1; base = done_cnt;
      pulse_start();
      for (int i = 0; i < 400 && done_cnt == base; i++) tick();
      tick(); tick();
      checks++;
      if (rx.size() != 129) begin
        errors++; $display("FAIL chk%0d_size: got %0d required 129", p, rx.size());
      end else if (rx[128] !== ((p == 0) ? 8'h00 : 8'hFF)) begin
        errors++; $display("FAIL chk%0d_byte: got %h required %h", p, rx[128], (p == 0) ? 8'h00 : 8'hFF);
      end
    end
  endtask
`endif

  initial begin
    for (int n = 0; n < 32; n++) bank[n] = 32'h0;
    tick(); tick();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_snapshot();
    test_start_busy();
`ifdef REG_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
